msh_bank_arb: RTL and testbench

MSH_BANK_ARB -- requirements
Module: msh_bank_arb

---
 rtl/msh_bank_arb.sv | 128 ++++++++++++
 tb/tb_msh_bank_arb.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msh_bank_arb.sv
// Mesh node memory bank arbiter: round-robin grant across the eight
// write/read ports with per-bank occupancy tracking, an optional
// read-priority mode, and a registered memory command plus credit return.
module msh_bank_arb #(
  parameter int unsigned NUM_REQ   = 8,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned BUSY_CYC  = 2
) (
  input  logic                                  mclk,
  input  logic                                  i_reset,
  input  logic [NUM_REQ-1:0]                    i_req_vld,
  input  logic [NUM_REQ-1:0]                    i_req_we,
  input  logic [NUM_REQ*$clog2(NUM_BANKS)-1:0]  i_req_bank,
  input  logic [NUM_REQ*ADDR_W-1:0]             i_req_addr,
  input  logic                                  i_cfg_rd_first,
  output logic [NUM_REQ-1:0]                    o_gnt,
  output logic                                  o_mem_vld,
  output logic                                  o_mem_we,
  output logic [$clog2(NUM_BANKS)-1:0]          o_mem_bank,
  output logic [ADDR_W-1:0]                     o_mem_addr,
  output logic [$clog2(NUM_REQ)-1:0]            o_mem_src,
  output logic [NUM_REQ-1:0]                    o_crdt_rtn,
  output logic [NUM_BANKS-1:0]                  o_bank_busy
);

  localparam int unsigned BANK_W = $clog2(NUM_BANKS);
  localparam int unsigned SRC_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W  = 4;

  logic [SRC_W-1:0]                  ptr;
  logic [SRC_W-1:0]                  ptr_nxt;
  logic [NUM_BANKS-1:0][CNT_W-1:0]   busy_cnt;
  logic [NUM_BANKS-1:0][CNT_W-1:0]   cnt_nxt;
  logic [NUM_BANKS-1:0]              busy_nxt;
  logic [NUM_REQ-1:0]                elig;
  logic [NUM_REQ-1:0]                rd_elig;
  logic [NUM_REQ-1:0]                cand;
  logic [SRC_W-1:0]                  scan_idx;
  logic                              gnt_any;
  logic                              win_we;
  logic [BANK_W-1:0]                 win_bank;
  logic [ADDR_W-1:0]                 win_addr;
  logic [SRC_W-1:0]                  win_src;

  // Eligibility filter, read-priority masking and round-robin scan from ptr.
  always_comb begin
    elig     = '0;
    rd_elig  = '0;
    cand     = '0;
    o_gnt    = '0;
    gnt_any  = 1'b0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = i_req_vld[i] & ~i_reset &
                (busy_cnt[i_req_bank[i*BANK_W +: BANK_W]] == '0);
    end
    rd_elig = elig & ~i_req_we;
    cand    = (i_cfg_rd_first && (rd_elig != '0)) ? rd_elig : elig;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = SRC_W'((32'(ptr) + 32'(k)) % NUM_REQ);
      if (!gnt_any && cand[scan_idx]) begin
        o_gnt[scan_idx] = 1'b1;
        gnt_any         = 1'b1;
      end
    end
  end

  // Select the winner's command fields from the one-hot grant.
  always_comb begin
    win_we   = 1'b0;
    win_bank = '0;
    win_addr = '0;
    win_src  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (o_gnt[i]) begin
        win_we   = i_req_we[i];
        win_bank = i_req_bank[i*BANK_W +: BANK_W];
        win_addr = i_req_addr[i*ADDR_W +: ADDR_W];
        win_src  = SRC_W'(i);
      end
    end
    ptr_nxt = SRC_W'((32'(win_src) + 32'd1) % NUM_REQ);
  end

  // Next occupancy: a granted bank reloads, any other busy bank counts down.
  always_comb begin
    cnt_nxt  = busy_cnt;
    busy_nxt = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (busy_cnt[b] != '0) begin
        cnt_nxt[b] = busy_cnt[b] - CNT_W'(1);
      end
      if (gnt_any && (win_bank == BANK_W'(b))) begin
        cnt_nxt[b] = CNT_W'(BUSY_CYC - 1);
      end
      busy_nxt[b] = (cnt_nxt[b] != '0);
    end
  end

  // Pointer, occupancy, memory command and credit-return registers.
  always_ff @(posedge mclk) begin
    if (i_reset) begin
      ptr         <= '0;
      busy_cnt    <= '0;
      o_mem_vld   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_bank  <= '0;
      o_mem_addr  <= '0;
      o_mem_src   <= '0;
      o_crdt_rtn  <= '0;
      o_bank_busy <= '0;
    end else begin
      busy_cnt    <= cnt_nxt;
      o_bank_busy <= busy_nxt;
      o_mem_vld   <= gnt_any;
      o_crdt_rtn  <= o_gnt;
      if (gnt_any) begin
        ptr        <= ptr_nxt;
        o_mem_we   <= win_we;
        o_mem_bank <= win_bank;
        o_mem_addr <= win_addr;
        o_mem_src  <= win_src;
      end
    end
  end

endmodule

// File: tb/tb_msh_bank_arb.sv
// Directed bench for msh_bank_arb with a timestamp-based reference model
// compared every cycle, plus literal expectations at key points.
module tb_msh_bank_arb;

  localparam int NR = 8;
  localparam int NB = 4;
  localparam int AW = 12;
  localparam int BC = 2;

  logic           mclk = 1'b0;
  logic           i_reset = 1'b1;
  logic [NR-1:0]  i_req_vld = '0;
  logic [NR-1:0]  i_req_we = '0;
  logic [NR*2-1:0] i_req_bank = '0;
  logic [NR*AW-1:0] i_req_addr = '0;
  logic           i_cfg_rd_first = 1'b0;
  logic [NR-1:0]  o_gnt;
  logic           o_mem_vld;
  logic           o_mem_we;
  logic [1:0]     o_mem_bank;
  logic [AW-1:0]  o_mem_addr;
  logic [2:0]     o_mem_src;
  logic [NR-1:0]  o_crdt_rtn;
  logic [NB-1:0]  o_bank_busy;

  int n_chk  = 0;
  int n_fail = 0;

  msh_bank_arb #(.NUM_REQ(NR), .NUM_BANKS(NB), .ADDR_W(AW), .BUSY_CYC(BC)) dut (
    .mclk(mclk), .i_reset(i_reset), .i_req_vld(i_req_vld), .i_req_we(i_req_we),
    .i_req_bank(i_req_bank), .i_req_addr(i_req_addr), .i_cfg_rd_first(i_cfg_rd_first),
    .o_gnt(o_gnt), .o_mem_vld(o_mem_vld), .o_mem_we(o_mem_we), .o_mem_bank(o_mem_bank),
    .o_mem_addr(o_mem_addr), .o_mem_src(o_mem_src), .o_crdt_rtn(o_crdt_rtn),
    .o_bank_busy(o_bank_busy)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each bank remembers the cycle of its last grant.
  int        cyc = 0;
  int        last_gnt [NB];
  int        m_ptr = 0;
  bit        regs_known = 0;
  bit        prev_reset = 1;
  logic        e_vld, e_we;
  logic [1:0]  e_bank;
  logic [AW-1:0] e_addr;
  logic [2:0]  e_src;
  logic [NR-1:0] e_crdt;
  logic [NB-1:0] e_busy;

  initial for (int b = 0; b < NB; b++) last_gnt[b] = -1000;

  always @(negedge mclk) begin
    logic [NR-1:0] elig;
    logic [NR-1:0] e_gnt;
    bit any_rd;
    int win;
    int bk;
    if (regs_known && !(i_reset && !prev_reset)) begin
      chk("mem_vld", 32'(o_mem_vld), 32'(e_vld));
      chk("mem_we", 32'(o_mem_we), 32'(e_we));
      chk("mem_bank", 32'(o_mem_bank), 32'(e_bank));
      chk("mem_addr", 32'(o_mem_addr), 32'(e_addr));
      chk("mem_src", 32'(o_mem_src), 32'(e_src));
      chk("crdt_rtn", 32'(o_crdt_rtn), 32'(e_crdt));
      chk("bank_busy", 32'(o_bank_busy), 32'(e_busy));
    end
    elig = '0; e_gnt = '0; any_rd = 0; win = -1;
    if (!i_reset) begin
      for (int i = 0; i < NR; i++) begin
        bk = int'(i_req_bank[i*2 +: 2]);
        elig[i] = i_req_vld[i] && (cyc - last_gnt[bk] >= BC);
        if (elig[i] && !i_req_we[i]) any_rd = 1;
      end
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (win < 0 && elig[idx] && !(i_cfg_rd_first && any_rd && i_req_we[idx])) win = idx;
      end
      if (win >= 0) e_gnt[win] = 1'b1;
    end
    chk("gnt", 32'(o_gnt), 32'(e_gnt));
    if (i_reset) begin
      m_ptr = 0;
      for (int b = 0; b < NB; b++) last_gnt[b] = -1000;
      e_vld = 0; e_we = 0; e_bank = 0; e_addr = 0; e_src = 0; e_crdt = 0; e_busy = 0;
    end else begin
      e_vld  = (win >= 0);
      e_crdt = e_gnt;
      if (win >= 0) begin
        e_we   = i_req_we[win];
        e_bank = i_req_bank[win*2 +: 2];
        e_addr = i_req_addr[win*AW +: AW];
        e_src  = 3'(win);
        last_gnt[int'(e_bank)] = cyc;
        m_ptr = (win + 1) % NR;
      end
      for (int b = 0; b < NB; b++) e_busy[b] = ((cyc + 1) - last_gnt[b] < BC);
    end
    prev_reset = i_reset;
    regs_known = 1;
    cyc++;
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic clear_reqs();
    i_req_vld = '0; i_req_we = '0; i_req_bank = '0; i_req_addr = '0;
  endtask

  task automatic set_req(input int i, input bit we, input int bank, input int addr);
    i_req_vld[i] = 1'b1;
    i_req_we[i] = we;
    i_req_bank[i*2 +: 2] = 2'(bank);
    i_req_addr[i*AW +: AW] = AW'(addr);
  endtask

  task automatic do_reset();
    tick();
    clear_reqs();
    i_reset = 1'b1;
    tick();
  endtask

  initial begin
    // Reset state
    tick(); tick(); tick();
    #1;
    chk("rst_gnt", 32'(o_gnt), 0);
    chk("rst_mem_vld", 32'(o_mem_vld), 0);
    chk("rst_busy", 32'(o_bank_busy), 0);
    chk("rst_crdt", 32'(o_crdt_rtn), 0);

    // All requesters valid on spread banks: grants sweep 0..7 then wrap to 0
    tick();
    i_reset = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, (i < 4), i % 4, 16 * i + 1);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      #1;
      chk("sweep_gnt", 32'(o_gnt), 32'(1) << (k % 8));
      if (k > 0) begin
        chk("sweep_crdt", 32'(o_crdt_rtn), 32'(1) << ((k - 1) % 8));
        chk("sweep_src", 32'(o_mem_src), 32'((k - 1) % 8));
      end
    end
    tick(); clear_reqs(); #1;
    chk("sweep_end_gnt", 32'(o_gnt), 0);
    chk("sweep_end_crdt", 32'(o_crdt_rtn), 32'h01);
    chk("sweep_end_addr", 32'(o_mem_addr), 32'h001);

    // Two requesters on bank 2: second waits out the occupancy
    do_reset();
    tick(); i_reset = 1'b0;
    set_req(0, 1, 2, 'h100); set_req(1, 1, 2, 'h101); #1;
    chk("bank_t0_gnt", 32'(o_gnt), 32'h01);
    tick(); i_req_vld[0] = 1'b0; #1;
    chk("bank_t1_gnt", 32'(o_gnt), 0);
    chk("bank_t1_busy", 32'(o_bank_busy), 32'h4);
    chk("bank_t1_addr", 32'(o_mem_addr), 32'h100);
    tick(); #1;
    chk("bank_t2_gnt", 32'(o_gnt), 32'h02);
    chk("bank_t2_busy", 32'(o_bank_busy), 0);
    chk("bank_t2_vld", 32'(o_mem_vld), 0);
    tick(); clear_reqs(); #1;
    chk("bank_t3_src", 32'(o_mem_src), 1);
    tick(); #1;
    chk("bank_t4_busy", 32'(o_bank_busy), 0);

    // Read-first: read 5 beats write 1; pointer then sits at 6
    do_reset();
    tick(); i_reset = 1'b0; i_cfg_rd_first = 1'b1;
    set_req(1, 1, 0, 'h011); set_req(5, 0, 1, 'h055); #1;
    chk("rdf_gnt0", 32'(o_gnt), 32'h20);
    tick(); i_req_vld[5] = 1'b0; set_req(6, 1, 3, 'h066); #1;
    chk("rdf_ptr6_gnt", 32'(o_gnt), 32'h40);
    chk("rdf_we", 32'(o_mem_we), 0);
    tick(); i_req_vld[6] = 1'b0; #1;
    chk("rdf_gnt1", 32'(o_gnt), 32'h02);
    tick(); clear_reqs(); i_cfg_rd_first = 1'b0; #1;
    chk("rdf_src1", 32'(o_mem_src), 1);

    // Pointer wrap 7 -> 0
    tick(); set_req(6, 0, 2, 'h0a6); #1;
    chk("wrap_pre", 32'(o_gnt), 32'h40);
    tick(); clear_reqs(); set_req(7, 1, 1, 'h0a7); set_req(0, 0, 0, 'h0a0); #1;
    chk("wrap_gnt7", 32'(o_gnt), 32'h80);
    tick(); i_req_vld[7] = 1'b0; #1;
    chk("wrap_gnt0", 32'(o_gnt), 32'h01);
    chk("wrap_src7", 32'(o_mem_src), 7);
    tick(); clear_reqs(); #1;
    chk("wrap_src0", 32'(o_mem_src), 0);

    // Reset right after a grant discards the pending pulse; ptr restarts at 0
    tick(); set_req(3, 1, 3, 'h333); #1;
    chk("rr_gnt3", 32'(o_gnt), 32'h08);
    tick(); clear_reqs(); i_reset = 1'b1; #1;
    chk("rr_gnt_in_rst", 32'(o_gnt), 0);
    tick(); i_reset = 1'b0; set_req(3, 1, 3, 'h334); set_req(5, 0, 0, 'h335); #1;
    chk("rr_vld", 32'(o_mem_vld), 0);
    chk("rr_crdt", 32'(o_crdt_rtn), 0);
    chk("rr_busy", 32'(o_bank_busy), 0);
    chk("rr_regrant", 32'(o_gnt), 32'h08);
    tick(); clear_reqs(); #1;
    chk("rr_addr", 32'(o_mem_addr), 32'h334);

    // Idle after a grant: command fields hold
    tick(); set_req(2, 1, 1, 'h5a5); #1;
    chk("hold_gnt", 32'(o_gnt), 32'h04);
    tick(); clear_reqs(); #1;
    chk("hold_vld1", 32'(o_mem_vld), 1);
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      chk("hold_vld0", 32'(o_mem_vld), 0);
      chk("hold_addr", 32'(o_mem_addr), 32'h5a5);
    end

    // Everyone on bank 0 with read priority: model tracks the contention
    tick(); i_cfg_rd_first = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, (i % 2) == 1, 0, 'h700 + i);
    repeat (8) tick();
    clear_reqs(); i_cfg_rd_first = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
